// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   localparam int unsigned WIDTH_DEFAULT = 8;
   localparam int unsigned CNT_W         = $clog2(WIDTH_DEFAULT);

   // Bit-counter width for a given operand width; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// Single-bit full subtractor: diff = a ^ b ^ bor, borrow out when a < b + bor.
module full_subtractor (
   input  logic a_in,
   input  logic b_in,
   input  logic bor_in,
   output logic diff_out,
   output logic bor_out
);

   logic a_xor_b;

   always_comb begin
      a_xor_b  = a_in ^ b_in;
      diff_out = a_xor_b ^ bor_in;
      bor_out  = (~a_in & b_in) | (~a_xor_b & bor_in);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first) with start/busy/done handshake.
// Define SERIAL_SUBTRACTOR_SIGNED_EN to enable the two's-complement overflow flag.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] diff_out,
   output logic             borrow_out,
   output logic             overflow_out
);

   localparam int unsigned CntW = cnt_width(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [CntW-1:0]  cnt_q;
   logic             bor_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;

   logic             bit_d;
   logic             bor_d;

   full_subtractor u_cell (
      .a_in     (a_q[0]),
      .b_in     (b_q[0]),
      .bor_in   (bor_q),
      .diff_out (bit_d),
      .bor_out  (bor_d)
   );

`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
   logic a_sign_q;
   logic b_sign_q;
   logic ovf_q;
`endif

   // Published results only move at the DONE->IDLE edge, together with done_out.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         bor_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
         a_sign_q <= 1'b0;
         b_sign_q <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_in) begin
                  a_q     <= a_in;
                  b_q     <= b_in;
                  res_q   <= '0;
                  cnt_q   <= '0;
                  bor_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
                  a_sign_q <= a_in[WIDTH-1];
                  b_sign_q <= b_in[WIDTH-1];
`endif
               end
            end
            RUN: begin
               a_q   <= {1'b0, a_q[WIDTH-1:1]};
               b_q   <= {1'b0, b_q[WIDTH-1:1]};
               res_q <= {bit_d, res_q[WIDTH-1:1]};
               bor_q <= bor_d;
               cnt_q <= cnt_q + CntW'(1);
               if (cnt_q == CntLast) begin
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q   <= 1'b1;
               diff_q   <= res_q;
               borrow_q <= bor_q;
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
               ovf_q    <= (a_sign_q != b_sign_q) && (res_q[WIDTH-1] != a_sign_q);
`endif
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      busy_out   = busy_q;
      done_out   = done_q;
      diff_out   = diff_q;
      borrow_out = borrow_q;
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
      overflow_out = ovf_q;
`else
      overflow_out = 1'b0;
`endif
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

   localparam int unsigned W = 8;
   localparam int LAT = W + 1;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] diff;
      logic         bor;
      logic         ovf_signed;
   } vec_t;

   vec_t vecs[9];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .start_in     (start),
      .a_in         (a_i),
      .b_in         (b_i),
      .busy_out     (busy),
      .done_out     (done),
      .diff_out     (diff),
      .borrow_out   (borrow),
      .overflow_out (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic exp_ovf(input logic signed_val);
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
      return signed_val;
`else
      return 1'b0 & signed_val;
`endif
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         input string tag);
      int  edges;
      bit  seen;
      logic [W-1:0] diff_at_done;
      @(negedge clk);
      a_i   = a;
      b_i   = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a_i   = ~a;
      b_i   = b ^ 8'h5A;
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      edges = 0;
      seen  = 0;
      while (!seen && edges < 20) begin
         @(posedge clk);
         edges++;
         #1;
         if (done) seen = 1;
      end
      check({tag, " latency"}, edges, LAT);
      check({tag, " diff"}, {24'd0, diff}, {24'd0, ed});
      check({tag, " borrow"}, {31'd0, borrow}, {31'd0, eb});
      check({tag, " overflow"}, {31'd0, ovf}, {31'd0, eo});
      check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
      diff_at_done = diff;
      @(posedge clk);
      #1;
      check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
      check({tag, " diff held"}, {24'd0, diff}, {24'd0, diff_at_done});
   endtask

   initial begin
      int pulses;
      int first_edge;

      vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
      vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
      vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
      vecs[4] = '{8'h33, 8'h33, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
      vecs[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
      vecs[7] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
      vecs[8] = '{8'hC0, 8'h40, 8'h80, 1'b0, 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      a_i   = '0;
      b_i   = '0;
      #12;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset diff", {24'd0, diff}, 32'd0);
      check("reset borrow", {31'd0, borrow}, 32'd0);
      check("reset overflow", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bor,
                exp_ovf(vecs[i].ovf_signed), $sformatf("vec%0d", i));
      end

      // Second start during RUN must be ignored.
      @(negedge clk);
      a_i   = 8'h05;
      b_i   = 8'h03;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      a_i   = 8'hFF;
      b_i   = 8'h00;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      pulses     = 0;
      first_edge = -1;
      for (int e = 4; e <= 24; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulses++;
            if (first_edge < 0) begin
               first_edge = e;
               check("ignore diff", {24'd0, diff}, 32'h02);
               check("ignore borrow", {31'd0, borrow}, 32'd0);
            end
         end
      end
      check("ignore pulses", pulses, 1);
      check("ignore latency", first_edge, LAT);

      // Reset during RUN aborts without a done pulse.
      @(negedge clk);
      a_i   = 8'h40;
      b_i   = 8'h01;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort diff", {24'd0, diff}, 32'd0);
      check("abort borrow", {31'd0, borrow}, 32'd0);
      check("abort overflow", {31'd0, ovf}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      pulses = 0;
      for (int e = 0; e < 15; e++) begin
         @(posedge clk);
         #1;
         if (done || busy) pulses++;
      end
      check("abort no activity", pulses, 0);
      run_op(8'h40, 8'h01, 8'h3F, 1'b0, 1'b0, "after abort");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
